// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples SCK/CS_N/MOSI on clk, receives one byte per
// eight sample edges and returns a byte on MISO in any CPOL/CPHA/bit-order mode.
module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_TX     = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       firstbit,
   input  logic [7:0] txdata,
   input  logic       tx_load,
   input  logic       SCK,
   input  logic       CS_N,
   input  logic       MOSI,
   output logic       MISO,
   output logic       miso_oe,
   output logic [7:0] rxdata,
   output logic       rx_valid,
   output logic       tx_full
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                   state;
   logic [SYNC_STAGES-1:0]   sck_sync;
   logic [SYNC_STAGES-1:0]   cs_sync;
   logic [SYNC_STAGES-1:0]   mosi_sync;
   logic                     sck_d;
   logic                     cs_d;
   logic [CNT_W-1:0]         bit_cnt;
   logic [BYTE_W-1:0]        tx_sr;
   logic [BYTE_W-1:0]        rx_sr;
   logic [BYTE_W-1:0]        tx_buf;
   logic                     start_pending;
   logic                     skip_shift;

   logic                     sck_s;
   logic                     cs_s;
   logic                     mosi_s;
   logic                     lead_edge;
   logic                     trail_edge;
   logic                     sample_edge;
   logic                     shift_edge;
   logic                     cs_fall;
   logic [BYTE_W-1:0]        start_byte;
   logic [BYTE_W-1:0]        adv_byte;
   logic [BYTE_W-1:0]        rx_next;

   // Synchronizers; idle values keep a freshly reset block from seeing an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= {SYNC_STAGES{cpol}};
         cs_sync   <= '1;
         mosi_sync <= '1;
         sck_d     <= cpol;
         cs_d      <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sck_d     <= sck_s;
         cs_d      <= cs_s;
      end
   end

   assign sck_s       = sck_sync[SYNC_STAGES-1];
   assign cs_s        = cs_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign lead_edge   = (sck_d == cpol) && (sck_s != cpol);
   assign trail_edge  = (sck_d != cpol) && (sck_s == cpol);
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge  : trail_edge;
   assign cs_fall     = cs_d && !cs_s;

   // A same-cycle load bypasses tx_buf and goes straight into the shifter
   assign start_byte = tx_load ? txdata : (tx_full ? tx_buf : IDLE_TX);
   assign adv_byte   = firstbit ? {tx_sr[BYTE_W-2:0], 1'b0} : {1'b0, tx_sr[BYTE_W-1:1]};
   assign rx_next    = firstbit ? {rx_sr[BYTE_W-2:0], mosi_s} : {mosi_s, rx_sr[BYTE_W-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         tx_sr         <= '0;
         rx_sr         <= '0;
         tx_buf        <= '0;
         tx_full       <= 1'b0;
         rxdata        <= '0;
         rx_valid      <= 1'b0;
         MISO          <= 1'b1;
         miso_oe       <= 1'b0;
         start_pending <= 1'b0;
         skip_shift    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (tx_load) begin
            tx_buf  <= txdata;
            tx_full <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (cs_fall) begin
                  state         <= ACTIVE;
                  bit_cnt       <= '0;
                  miso_oe       <= 1'b1;
                  tx_sr         <= start_byte;
                  MISO          <= firstbit ? start_byte[BYTE_W-1] : start_byte[0];
                  tx_full       <= 1'b0;
                  start_pending <= 1'b0;
                  // With cpha=1 the first leading edge only presents bit 0
                  skip_shift    <= cpha;
               end
            end
            ACTIVE: begin
               if (cs_s) begin
                  state         <= IDLE;
                  bit_cnt       <= '0;
                  miso_oe       <= 1'b0;
                  MISO          <= 1'b1;
                  start_pending <= 1'b0;
                  skip_shift    <= 1'b0;
               end else begin
                  if (sample_edge) begin
                     rx_sr   <= rx_next;
                     bit_cnt <= CNT_W'(bit_cnt + CNT_W'(1));
                     if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                        rxdata        <= rx_next;
                        rx_valid      <= 1'b1;
                        start_pending <= 1'b1;
                     end
                  end
                  if (shift_edge) begin
                     if (start_pending) begin
                        tx_sr         <= start_byte;
                        MISO          <= firstbit ? start_byte[BYTE_W-1] : start_byte[0];
                        tx_full       <= 1'b0;
                        start_pending <= 1'b0;
                        skip_shift    <= 1'b0;
                     end else if (skip_shift) begin
                        skip_shift <= 1'b0;
                     end else begin
                        tx_sr <= adv_byte;
                        MISO  <= firstbit ? adv_byte[BYTE_W-1] : adv_byte[0];
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives the pins; received bytes
// are scoreboarded against the bytes the master sent, MISO bytes against the loaded ones.
module tb_spi_slave;

   localparam int unsigned H = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpol, cpha, firstbit;
   logic [7:0] txdata;
   logic       tx_load;
   logic       SCK, CS_N, MOSI;
   logic       MISO, miso_oe;
   logic [7:0] rxdata;
   logic       rx_valid, tx_full;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_rx_q[$];

   always #5 clk = ~clk;

   spi_slave #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .firstbit(firstbit),
      .txdata(txdata), .tx_load(tx_load), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI),
      .MISO(MISO), .miso_oe(miso_oe), .rxdata(rxdata), .rx_valid(rx_valid),
      .tx_full(tx_full)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every rx_valid pulse must match the oldest byte the master sent
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rx_valid === 1'b1) begin
         if (exp_rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_valid_unexpected: got rxdata %0h expected no pulse", rxdata);
         end else begin
            check("rxdata_scoreboard", 32'(rxdata), 32'(exp_rx_q.pop_front()));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "timeout");
   end

   task automatic wait_h();
      repeat (H) @(negedge clk);
   endtask

   task automatic set_mode(input logic c, input logic p, input logic f);
      @(negedge clk);
      cpol = c; cpha = p; firstbit = f; SCK = c;
      repeat (8) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] d);
      @(negedge clk);
      txdata = d; tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   task automatic cs_low();
      CS_N = 1'b0;
      wait_h();
   endtask

   task automatic cs_high();
      wait_h();
      CS_N = 1'b1;
      repeat (2 * H) @(negedge clk);
   endtask

   // Master side of one byte (or a partial byte of nbits sample edges)
   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      int idx;
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         idx = firstbit ? 7 - i : i;
         if (!cpha) begin
            MOSI = tx[idx];
            wait_h();
            SCK = ~cpol;
            rx[idx] = MISO;
            wait_h();
            SCK = cpol;
         end else begin
            SCK = ~cpol;
            MOSI = tx[idx];
            wait_h();
            SCK = cpol;
            rx[idx] = MISO;
            wait_h();
         end
      end
   endtask

   task automatic full_byte(input logic [7:0] tx, input logic [7:0] exp_miso, input string name);
      logic [7:0] r;
      exp_rx_q.push_back(tx);
      xfer(tx, 8, r);
      check(name, 32'(r), 32'(exp_miso));
   endtask

   initial begin
      logic [7:0] r1, r2, prev;
      logic       found;
      rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; firstbit = 1'b1;
      txdata = 8'h00; tx_load = 1'b0; SCK = 1'b0; CS_N = 1'b1; MOSI = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_miso", 32'(MISO), 32'd1);
      check("reset_miso_oe", 32'(miso_oe), 32'd0);
      check("reset_rxdata", 32'(rxdata), 32'h00);
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_tx_full", 32'(tx_full), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Mode 0, MSB first
      set_mode(1'b0, 1'b0, 1'b1);
      load(8'hA5);
      check("t1_tx_full_set", 32'(tx_full), 32'd1);
      cs_low();
      check("t1_miso_oe", 32'(miso_oe), 32'd1);
      check("t1_miso_bit7_early", 32'(MISO), 32'd1);
      full_byte(8'h66, 8'hA5, "t1_master_rx");
      cs_high();
      check("t1_rxdata", 32'(rxdata), 32'h66);
      check("t1_tx_full_clear", 32'(tx_full), 32'd0);

      // Mode 3, LSB first
      set_mode(1'b1, 1'b1, 1'b0);
      load(8'h3C);
      cs_low();
      full_byte(8'h81, 8'h3C, "t2_master_rx");
      cs_high();
      check("t2_rxdata", 32'(rxdata), 32'h81);

      // Continuous two-byte transfer; second tx byte loaded after first rx_valid
      set_mode(1'b0, 1'b0, 1'b1);
      load(8'h55);
      cs_low();
      exp_rx_q.push_back(8'h12);
      exp_rx_q.push_back(8'h34);
      fork
         begin
            xfer(8'h12, 8, r1);
            xfer(8'h34, 8, r2);
         end
         begin
            found = 1'b0;
            for (int i = 0; i < 400; i++) begin
               if (rx_valid === 1'b1) begin
                  found = 1'b1;
                  break;
               end
               @(negedge clk);
            end
            check("t3_first_rx_valid_seen", 32'(found), 32'd1);
            load(8'hAA);
         end
      join
      cs_high();
      check("t3_master_rx0", 32'(r1), 32'h55);
      check("t3_master_rx1", 32'(r2), 32'hAA);

      // No load gives the idle byte; back-to-back loads keep only the last
      cs_low();
      full_byte(8'h5E, 8'hFF, "t4_idle_byte");
      cs_high();
      check("t4_tx_full_idle", 32'(tx_full), 32'd0);
      @(negedge clk);
      txdata = 8'h11; tx_load = 1'b1;
      @(negedge clk);
      txdata = 8'h22;
      @(negedge clk);
      tx_load = 1'b0;
      check("t4_tx_full_loaded", 32'(tx_full), 32'd1);
      cs_low();
      full_byte(8'h01, 8'h22, "t4_overwrite");
      cs_high();
      cs_low();
      full_byte(8'h02, 8'hFF, "t4_no_stale");
      cs_high();

      // Abort after three sample edges
      prev = rxdata;
      cs_low();
      xfer(8'hF0, 3, r1);
      cs_high();
      check("t5_abort_rxdata", 32'(rxdata), 32'(prev));
      check("t5_abort_miso_oe", 32'(miso_oe), 32'd0);
      check("t5_abort_miso", 32'(MISO), 32'd1);
      cs_low();
      full_byte(8'hC3, 8'hFF, "t5_after_abort");
      cs_high();
      check("t5_rxdata", 32'(rxdata), 32'hC3);

      // Reset mid-byte
      load(8'h77);
      cs_low();
      xfer(8'hA5, 4, r1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_miso", 32'(MISO), 32'd1);
      check("t6_rst_miso_oe", 32'(miso_oe), 32'd0);
      check("t6_rst_rxdata", 32'(rxdata), 32'h00);
      check("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
      check("t6_rst_tx_full", 32'(tx_full), 32'd0);
      @(negedge clk);
      CS_N = 1'b1; SCK = cpol;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      load(8'h96);
      cs_low();
      full_byte(8'h5A, 8'h96, "t6_after_reset");
      cs_high();
      check("t6_rxdata", 32'(rxdata), 32'h5A);

      // Randomized modes, orders, loads and one- or two-byte transfers
      for (int it = 0; it < 30; it++) begin
         logic [7:0] d, m0, m1;
         logic       ld;
         int         nb;
         set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         ld = 1'($urandom_range(0, 1));
         d  = 8'($urandom);
         if (ld) load(d);
         nb = $urandom_range(1, 2);
         cs_low();
         m0 = 8'($urandom);
         full_byte(m0, ld ? d : 8'hFF, "rand_master_rx0");
         if (nb == 2) begin
            m1 = 8'($urandom);
            full_byte(m1, 8'hFF, "rand_master_rx1");
         end
         cs_high();
         check("rand_tx_full", 32'(tx_full), 32'd0);
      end

      repeat (4) @(negedge clk);
      check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave (target) endpoint that pairs with spi_master on the same bus, for example as a peripheral model or an off-chip bridge.
- Oversamples SCK, CS_N and MOSI on the system clock through synchronizers.
- Shifts in one byte per 8 SCK sample edges and returns a byte on MISO.
- Supports all four CPOL/CPHA modes and MSB- or LSB-first ordering, using the same mode inputs as the master.

Parameters:
SYNC_STAGES, 2, synchronizer depth on SCK/CS_N/MOSI (legal values 2..3).
IDLE_TX, 8'hFF, byte shifted out when no tx byte is pending at byte start.

Ports:
clk  input  1  system clock; must be at least 8x SCK frequency.
rst_n  input  1  asynchronous active-low reset.
cpol  input  1  SCK idle level; static while CS_N is low.
cpha  input  1  0: sample on the leading edge; 1: sample on the trailing edge.
firstbit  input  1  1: MSB first; 0: LSB first.
txdata  input  8  byte to return to the master.
tx_load  input  1  1-clk pulse; captures txdata into tx_buf.
SCK  input  1  serial clock from master (asynchronous).
CS_N  input  1  chip select, active low (asynchronous).
MOSI  input  1  serial data from master (asynchronous).
MISO  output  1  serial data to master.
miso_oe  output  1  MISO drive enable for an external tristate; 1 while selected.
rxdata  output  8  last complete received byte.
rx_valid  output  1  1-clk pulse when rxdata updates.
tx_full  output  1  tx_buf holds a byte not yet consumed.

Behaviour:
Reset (rst_n=0, async):
- MISO=1, miso_oe=0, rxdata=8'h00, rx_valid=0, tx_full=0.
- State=IDLE, bit_cnt=0, all synchronizer flops set to their idle values (SCK=cpol, CS_N=1).

Input synchronization and edge detection:
- SCK, CS_N and MOSI each pass through SYNC_STAGES flops.
- One further SCK flop provides edge detection.
- Leading edge: synced SCK leaves the cpol level. Trailing edge: it returns to cpol.
- Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other edge.

State machine: IDLE, ACTIVE.
IDLE -> ACTIVE on synced CS_N falling:
- bit_cnt=0, miso_oe=1.
- Load tx shifter (see byte start); MISO shows the first bit in the same cycle.
ACTIVE, on a sample edge:
- Shift synced MOSI into rx shifter: into bit 0 with left shift if firstbit=1, into bit 7 with right shift if firstbit=0.
- bit_cnt++.
- On the 8th sample edge (bit_cnt 7->0): rxdata <= completed byte and rx_valid=1 the next clk. Arm a byte start for the next shift edge.
ACTIVE, on a shift edge:
- Advance the tx shifter so the next bit is on MISO.
- cpha=1: the first leading edge of a byte is a shift edge, but MISO already holds bit 0 from the byte start. That edge presents bit 0 and is not an advance.
- cpha=0: the shift edge after the 8th sample edge performs the byte start for the following byte (continuous transfer, CS_N held low).
ACTIVE -> IDLE on synced CS_N rising, at any bit_cnt:
- Abort: bit_cnt=0, miso_oe=0, MISO=1.
- A partial byte is discarded: no rx_valid, rxdata unchanged.
- A byte already loaded from tx_buf is lost; tx_full is not restored.

Byte start:
- If tx_full=1: tx shifter <= tx_buf, tx_full=0.
- Otherwise: tx shifter <= IDLE_TX.
- MISO = shifter[7] if firstbit=1, shifter[0] if firstbit=0.

tx_load:
- Sets tx_buf=txdata and tx_full=1 in any state.
- A load while tx_full=1 overwrites tx_buf.
- tx_load in the same clk as a byte start: txdata goes straight to the shifter and tx_full stays 0.

Latency and timing:
- MISO changes SYNC_STAGES+1 clks after the SCK shift edge at the pin.
- The master's SCK half-period must be at least 4 clk.

Mode changes: cpol, cpha and firstbit changes while CS_N=0 are unsupported.

Test Plan:
1. Mode 0, MSB first, psc=4: tx_load 8'hA5, then master sends 8'h66 -> rxdata=8'h66 with a single rx_valid pulse; master rxdata=8'hA5; MISO bit 7 valid before the first rising SCK.
2. Mode 3 (cpol=1, cpha=1), LSB first: slave loads 8'h3C, master sends 8'h81 -> slave rxdata=8'h81, master receives 8'h3C.
3. Continuous transfer, CS_N held low across two bytes: master sends 8'h12 then 8'h34; slave loads 8'h55, then 8'hAA after the first rx_valid -> two rx_valid pulses (8'h12, 8'h34); master gets 8'h55 then 8'hAA.
4. No tx_load before a transfer -> master receives 8'hFF and tx_full stays 0; tx_load of two bytes back-to-back -> only the second is sent.
5. CS_N raised after 3 SCK sample edges -> no rx_valid, rxdata holds its prior value, miso_oe=0 and MISO=1; the next full byte 8'hC3 is received correctly.
6. rst_n asserted mid-byte -> all outputs at reset values immediately; after release, a mode 0 transfer of 8'h5A completes correctly.
